// File: rtl/cpu_mem_pkg.sv
// Shared memory-path definitions: access size encodings (common to the load
// and store paths), lane geometry, and the store sequencer state type.
package cpu_mem_pkg;

   // Access size encodings, identical on the load and store paths
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_ILL  = 2'b11;

   // Lane geometry of a 32-bit little-endian word
   localparam int LANE_W    = 8;
   localparam int NUM_LANES = 4;

   // Lane enable patterns, bit i covers bits [8*i+7:8*i]
   localparam logic [3:0] LANE_0        = 4'b0001;
   localparam logic [3:0] LANES_LO_HALF = 4'b0011;
   localparam logic [3:0] LANES_HI_HALF = 4'b1100;
   localparam logic [3:0] LANES_ALL     = 4'b1111;

   // Store sequencer states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_READ  = 3'd2,
      ST_MERGE = 3'd3,
      ST_WRITE = 3'd4,
      ST_DONE  = 3'd5
   } store_state_t;

   // True when the access cannot be performed: illegal size or bad alignment
   function automatic logic store_rejected(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b1;
      case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = addr_lo[0];
         SIZE_WORD: bad = (addr_lo != 2'b00);
         default:   bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: overlays the narrowed store data onto an old
// memory word. Little-endian, lane 0 is bits [7:0]. Illegal size leaves the
// word untouched.
module store_lane_merge
   import cpu_mem_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] data,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   output logic [31:0] merged
);

   logic [3:0]  lane_en;
   logic [31:0] src;

   // Replicate the narrowed data across lanes, then pick lanes by enable
   always_comb begin
      lane_en = 4'b0000;
      src     = data;
      merged  = old_word;
      case (size)
         SIZE_BYTE: begin
            lane_en = LANE_0 << addr_lo;
            src     = {4{data[7:0]}};
         end
         SIZE_HALF: begin
            lane_en = addr_lo[1] ? LANES_HI_HALF : LANES_LO_HALF;
            src     = {2{data[15:0]}};
         end
         SIZE_WORD: begin
            lane_en = LANES_ALL;
            src     = data;
         end
         default: begin
            lane_en = 4'b0000;
            src     = data;
         end
      endcase
      for (int i = 0; i < NUM_LANES; i++) begin
         if (lane_en[i]) begin
            merged[i*LANE_W +: LANE_W] = src[i*LANE_W +: LANE_W];
         end
      end
   end

endmodule

// File: rtl/store_narrow_rmw.sv
// Store narrowing unit: writes byte/half/word stores to a word-only memory.
// Word stores write directly; sub-word stores read the word, merge the new
// lanes and write it back. Misaligned or illegal requests finish with err_o
// and never touch memory.
//
// Handshakes:
//   request : accepted on the rising edge where req_valid_i && req_ready_o;
//             req_ready_o is high only while idle, inputs are captured then.
//   memory  : mem_rd_o / mem_wr_o are held, with mem_addr_o and mem_wdata_o
//             stable, until the edge where mem_ack_i is high; ack is ignored
//             whenever neither strobe is up. The two strobes never overlap.
//   done    : done_o is a one-cycle pulse; err_o is meaningful only with it.
module store_narrow_rmw
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [1:0]        size_i,
   output logic              done_o,
   output logic              err_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_rd_o,
   output logic              mem_wr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i,
   output store_state_t      state_o
);

   store_state_t      state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [1:0]        size_q;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] wdata_q;
   logic              err_q;
   logic              accept;
   logic              reject;
   logic [DATA_W-1:0] merged;

   assign accept = req_valid_i && req_ready_o;
   assign reject = store_rejected(size_q, addr_q[1:0]);

   store_lane_merge u_merge (
      .old_word (rdata_q),
      .data     (data_q),
      .addr_lo  (addr_q[1:0]),
      .size     (size_q),
      .merged   (merged)
   );

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (reject)                  state_d = ST_DONE;
            else if (size_q == SIZE_WORD) state_d = ST_WRITE;
            else                          state_d = ST_READ;
         end
         ST_READ: begin
            if (mem_ack_i) state_d = ST_MERGE;
         end
         ST_MERGE: begin
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            if (mem_ack_i) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Request capture, read-data latch and write-word construction
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         addr_q  <= '0;
         data_q  <= '0;
         size_q  <= SIZE_BYTE;
         rdata_q <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            addr_q <= addr_i;
            data_q <= data_i;
            size_q <= size_i;
         end
         if (state_q == ST_CHECK) begin
            err_q <= reject;
            if (!reject && size_q == SIZE_WORD) wdata_q <= data_q;
         end
         if (state_q == ST_READ && mem_ack_i) rdata_q <= mem_rdata_i;
         if (state_q == ST_MERGE) wdata_q <= merged;
      end
   end

   assign req_ready_o = (state_q == ST_IDLE);
   assign mem_rd_o    = (state_q == ST_READ);
   assign mem_wr_o    = (state_q == ST_WRITE);
   assign done_o      = (state_q == ST_DONE);
   assign err_o       = (state_q == ST_DONE) && err_q;
   assign mem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_wdata_o = wdata_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Bench for store_narrow_rmw: a memory responder with programmable wait
// states, a byte-level reference memory, and one negedge compare process.
module tb_store_narrow_rmw;
   import cpu_mem_pkg::*;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         req_valid_i;
   logic         req_ready_o;
   logic [31:0]  addr_i;
   logic [31:0]  data_i;
   logic [1:0]   size_i;
   logic         done_o;
   logic         err_o;
   logic [31:0]  mem_addr_o;
   logic         mem_rd_o;
   logic         mem_wr_o;
   logic [31:0]  mem_wdata_o;
   logic [31:0]  mem_rdata_i;
   logic         mem_ack_i;
   store_state_t state_o;

   store_narrow_rmw #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .addr_i      (addr_i),
      .data_i      (data_i),
      .size_i      (size_i),
      .done_o      (done_o),
      .err_o       (err_o),
      .mem_addr_o  (mem_addr_o),
      .mem_rd_o    (mem_rd_o),
      .mem_wr_o    (mem_wr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .mem_ack_i   (mem_ack_i),
      .state_o     (state_o)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk_i = ~clk_i;

   int cyc = 0;
   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   // ---------------- bookkeeping ----------------
   int n_vec = 0;
   int n_err = 0;

   logic [31:0] mem_real [logic [31:0]];   // what the DUT actually wrote
   logic [31:0] ref_mem  [logic [31:0]];   // what the rules say memory holds
   logic [31:0] exp_q[$];                  // expected write words, in order

   // expectations for the transaction in flight (written by the driver)
   logic [31:0] exp_addr;
   logic        exp_err;
   logic        exp_rd;
   int          exp_lat;
   int          acc_cyc;
   int          n_acc = 0;
   int          rd_wait = 0;
   int          wr_wait = 0;
   logic [31:0] saved_wa;
   logic [31:0] saved_word;

   // results of the last finished transaction (written by the compare process)
   int          n_done = 0;
   logic [31:0] last_wdata;
   int          last_lat;
   logic        last_err;
   int          last_rd_cyc;
   int          last_wr_cyc;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- memory responder ----------------
   // Acks after the programmed number of wait cycles; toggles ack randomly
   // while no strobe is up, and drives junk read data except on a read ack.
   initial begin : mem_responder
      int cnt;
      cnt = 0;
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
      forever begin
         @(posedge clk_i);
         #1;
         if (!rst_i) begin
            mem_ack_i = 1'b0;
            cnt = 0;
         end else if (mem_rd_o || mem_wr_o) begin
            if (cnt >= (mem_rd_o ? rd_wait : wr_wait)) begin
               mem_ack_i = 1'b1;
               if (mem_rd_o) begin
                  mem_rdata_i = mem_real.exists(mem_addr_o) ? mem_real[mem_addr_o] : 32'h0;
               end else begin
                  mem_real[mem_addr_o] = mem_wdata_o;
                  mem_rdata_i = $urandom;
               end
               cnt = 0;
            end else begin
               mem_ack_i   = 1'b0;
               mem_rdata_i = $urandom;
               cnt++;
            end
         end else begin
            mem_ack_i   = 1'($urandom_range(0, 1));
            mem_rdata_i = $urandom;
            cnt = 0;
         end
      end
   end

   // ---------------- compare process ----------------
   initial begin : compare
      int   seen_acc;
      int   rd_cyc;
      int   wr_cyc;
      logic busy;
      logic [31:0] act_wdata;
      seen_acc  = 0;
      rd_cyc    = 0;
      wr_cyc    = 0;
      act_wdata = '0;
      forever begin
         @(negedge clk_i);
         if (rst_i === 1'b1) begin
            if (n_acc != seen_acc) begin
               seen_acc = n_acc;
               rd_cyc = 0;
               wr_cyc = 0;
            end
            busy = (n_acc != n_done);
            chk("rd_wr_exclusive", 32'(mem_rd_o && mem_wr_o), 32'd0);
            chk("req_ready", 32'(req_ready_o), 32'(!busy));
            if (mem_rd_o) begin
               rd_cyc++;
               chk("rd_allowed", 32'(busy && exp_rd), 32'd1);
               chk("rd_addr", mem_addr_o, exp_addr);
            end
            if (mem_wr_o) begin
               wr_cyc++;
               act_wdata = mem_wdata_o;
               chk("wr_addr", mem_addr_o, exp_addr);
               if (exp_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
               else                   chk("wr_data", mem_wdata_o, exp_q[0]);
            end
            if (done_o) begin
               chk("done_in_txn", 32'(busy), 32'd1);
               if (busy) begin
                  chk("done_err", 32'(err_o), 32'(exp_err));
                  chk("done_latency", 32'(cyc - acc_cyc), 32'(exp_lat));
                  chk("did_read", 32'(rd_cyc != 0), 32'(exp_rd));
                  chk("did_write", 32'(wr_cyc != 0), 32'(!exp_err));
                  if (!exp_err) begin
                     if (exp_q.size() != 0) void'(exp_q.pop_front());
                     chk("mem_contents",
                         mem_real.exists(exp_addr) ? mem_real[exp_addr] : 32'hx,
                         ref_mem[exp_addr]);
                  end
                  last_wdata  = act_wdata;
                  last_lat    = cyc - acc_cyc;
                  last_err    = err_o;
                  last_rd_cyc = rd_cyc;
                  last_wr_cyc = wr_cyc;
                  n_done++;
               end
            end else begin
               chk("err_without_done", 32'(err_o), 32'd0);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Computes the expected outcome from the access rules and issues the request.
   task automatic issue(input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] s, input int rw, input int ww);
      logic [31:0] wa;
      logic [31:0] w;
      int          nb;
      int          lane;
      @(negedge clk_i);
      rd_wait = rw;
      wr_wait = ww;
      wa = {a[31:2], 2'b00};
      if (!ref_mem.exists(wa)) begin
         w = $urandom;
         ref_mem[wa]  = w;
         mem_real[wa] = w;
      end
      saved_wa   = wa;
      saved_word = ref_mem[wa];
      exp_addr = wa;
      exp_err  = (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
      exp_rd   = !exp_err && (s != 2'b10);
      if (exp_err)     exp_lat = 2;
      else if (exp_rd) exp_lat = 5 + rw + ww;
      else             exp_lat = 3 + ww;
      if (!exp_err) begin
         w  = ref_mem[wa];
         nb = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
         for (int i = 0; i < nb; i++) begin
            lane = int'(a[1:0]) + i;
            w[8*lane +: 8] = d[8*i +: 8];
         end
         ref_mem[wa] = w;
         exp_q.push_back(w);
      end
      addr_i      = a;
      data_i      = d;
      size_i      = s;
      req_valid_i = 1'b1;
      acc_cyc     = cyc;
      @(posedge clk_i);
      n_acc++;
      #1;
      req_valid_i = 1'b0;
      addr_i      = $urandom;
      data_i      = $urandom;
      size_i      = 2'($urandom_range(0, 3));
   endtask

   task automatic pulse_reset();
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i);
      #2;
      ref_mem[saved_wa] = saved_word;
      exp_q.delete();
      n_acc = n_done;
      @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (n_done != n_acc && t < 200) begin
         @(posedge clk_i);
         t++;
      end
      if (n_done != n_acc) begin
         chk("done_timeout", 32'd0, 32'd1);
         pulse_reset();
      end
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] s, input int rw, input int ww);
      issue(a, d, s, rw, ww);
      wait_done();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
      chk({tag, "_done"},  32'(done_o), 32'd0);
      chk({tag, "_err"},   32'(err_o), 32'd0);
      chk({tag, "_rd"},    32'(mem_rd_o), 32'd0);
      chk({tag, "_wr"},    32'(mem_wr_o), 32'd0);
      chk({tag, "_addr"},  mem_addr_o, 32'd0);
      chk({tag, "_wdata"}, mem_wdata_o, 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      int t;
      rst_i       = 1'b0;
      req_valid_i = 1'b0;
      addr_i      = '0;
      data_i      = '0;
      size_i      = '0;
      repeat (2) @(posedge clk_i);
      #2;
      check_reset_outputs("reset");
      @(negedge clk_i);
      rst_i = 1'b1;

      // word store, zero wait
      store(32'h100, 32'hDEADBEEF, 2'b10, 0, 0);
      chk("word_wdata", last_wdata, 32'hDEADBEEF);
      chk("word_lat", 32'(last_lat), 32'd3);
      chk("word_err", 32'(last_err), 32'd0);
      chk("word_no_read", 32'(last_rd_cyc), 32'd0);
      chk("word_mem", mem_real[32'h100], 32'hDEADBEEF);

      // byte store into a known word
      mem_real[32'h200] = 32'h11223344;
      ref_mem[32'h200]  = 32'h11223344;
      store(32'h203, 32'h123456AB, 2'b00, 0, 0);
      chk("byte_wdata", last_wdata, 32'hAB223344);
      chk("byte_lat", 32'(last_lat), 32'd5);
      chk("byte_read", 32'(last_rd_cyc), 32'd1);

      // half store into the upper half
      mem_real[32'h300] = 32'hAAAABBBB;
      ref_mem[32'h300]  = 32'hAAAABBBB;
      store(32'h302, 32'hFFFF8001, 2'b01, 0, 0);
      chk("half_wdata", last_wdata, 32'h8001BBBB);
      chk("half_lat", 32'(last_lat), 32'd5);

      // rejected requests
      store(32'h401, 32'h0000CAFE, 2'b01, 0, 0);
      chk("misalign_err", 32'(last_err), 32'd1);
      chk("misalign_lat", 32'(last_lat), 32'd2);
      chk("misalign_no_mem", 32'(last_rd_cyc + last_wr_cyc), 32'd0);
      store(32'h404, 32'h12345678, 2'b11, 0, 0);
      chk("illegal_err", 32'(last_err), 32'd1);
      chk("illegal_lat", 32'(last_lat), 32'd2);
      chk("illegal_no_mem", 32'(last_rd_cyc + last_wr_cyc), 32'd0);

      // wait states on read and write
      mem_real[32'h600] = 32'h01020304;
      ref_mem[32'h600]  = 32'h01020304;
      store(32'h600, 32'h0000BEEF, 2'b01, 3, 3);
      chk("wait_wdata", last_wdata, 32'h0102BEEF);
      chk("wait_lat", 32'(last_lat), 32'd11);
      chk("wait_rd_cycles", 32'(last_rd_cyc), 32'd4);
      chk("wait_wr_cycles", 32'(last_wr_cyc), 32'd4);

      // reset while the read strobe is held
      issue(32'h701, 32'h000000EE, 2'b00, 20, 0);
      t = 0;
      while (!mem_rd_o && t < 20) begin
         @(negedge clk_i);
         t++;
      end
      chk("reached_read", 32'(mem_rd_o), 32'd1);
      rst_i = 1'b0;
      @(posedge clk_i);
      #2;
      check_reset_outputs("abort");
      ref_mem[saved_wa] = saved_word;
      exp_q.delete();
      n_acc = n_done;
      @(negedge clk_i);
      rst_i = 1'b1;
      store(32'h800, 32'h5A5AA5A5, 2'b10, 0, 0);
      chk("after_abort_wdata", last_wdata, 32'h5A5AA5A5);
      chk("after_abort_lat", 32'(last_lat), 32'd3);

      // randomized stores over a small region so RMW sees earlier writes
      for (int k = 0; k < 80; k++) begin
         store(32'h1000 + 32'($urandom_range(0, 31)), $urandom,
               2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3));
      end

      repeat (3) @(posedge clk_i);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/store_narrow_rmw.md
Name: store_narrow_rmw

Overview:
- Store-side counterpart of the load-path sign extender: narrows a 32-bit register value to byte, halfword or word and writes it to a word-only data memory.
- Sub-word stores use read-modify-write: read the word, merge the narrowed lanes, write it back.
- Sits between the CPU memory stage and data memory; stalls the pipeline via ready/done handshake.

Parameters:
- ADDR_W, 32, address width in bits; bits [1:0] select the byte lane.
- DATA_W, 32, data word width; fixed at 32, not re-sized.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset; one clock; reset is synchronous and active-low
- req_valid_i  input  1  store request present
- req_ready_o  output  1  block idle, request accepted this cycle if valid
- addr_i  input  32  byte address
- data_i  input  32  register value to store; low bits used for sub-word
- size_i  input  2  00 byte, 01 half, 10 word, 11 illegal
- done_o  output  1  one-cycle pulse: store finished or rejected
- err_o  output  1  valid with done_o: misaligned or illegal size, no memory write
- mem_addr_o  output  32  word address {addr[31:2],2'b00}
- mem_rd_o  output  1  memory read strobe, held until mem_ack_i
- mem_wr_o  output  1  memory write strobe, held until mem_ack_i
- mem_wdata_o  output  32  merged word to write
- mem_rdata_i  input  32  read data, valid when mem_ack_i with mem_rd_o
- mem_ack_i  input  1  memory completes the current read or write

Behaviour:
- Reset (rst_i=0 at posedge) values:
  - state IDLE; req_ready_o=1.
  - done_o, err_o, mem_rd_o, mem_wr_o = 0.
  - mem_addr_o and mem_wdata_o = 0.
  - Reset mid-operation aborts immediately; any held strobe drops the next cycle.
- Request capture:
  - Accept on req_valid_i && req_ready_o.
  - addr, data and size are registered; inputs are ignored afterwards.
- States:
  - IDLE: on accept, go to CHECK.
  - CHECK:
    - Error if size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=0.
    - Error -> DONE with err.
    - Word -> WRITE with mem_wdata_o = data.
    - Byte or half -> READ.
  - READ: mem_rd_o=1 until mem_ack_i; on ack, latch mem_rdata_i and go to MERGE.
  - MERGE: build mem_wdata_o from the latched word (little-endian lanes), then go to WRITE.
    - Byte: lane addr[1:0] gets data[7:0].
    - Half: lanes {addr[1],1} and {addr[1],0} get data[15:0].
    - All other lanes keep the read bytes.
  - WRITE: mem_wr_o=1, with mem_addr_o and mem_wdata_o stable, until mem_ack_i; then DONE.
  - DONE: done_o=1 for one cycle (err_o=1 if error path); return to IDLE.
- req_ready_o is 1 only in IDLE.
- Truncation only: upper bits of data_i are discarded, never sign-checked.
- mem_rd_o and mem_wr_o are never high together.
- mem_ack_i outside READ or WRITE is ignored.
- Latency with zero-wait memory (ack in the first strobe cycle): word 3 cycles accept->done, sub-word 5, error 2.
- A new request may be accepted in the cycle after done_o.
- A stalled ack holds state indefinitely; there is no timeout.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings, shared with the load path.
  - State enum.
  - Lane-index constants.
- One natural sub-module: store_lane_merge (combinational; old word, data, addr[1:0], size -> merged word), reusable by the load path's inverse lane select.

Test Plan:
- Word store: addr=0x100, data=0xDEADBEEF, size=10, ack immediate -> one write to 0x100 of 0xDEADBEEF, no read, done at cycle 3, err=0.
- Byte store: addr=0x203, data=0x123456AB, size=00, memory word=0x11223344 -> read 0x200, write 0xAB223344, done at cycle 5.
- Half store: addr=0x302, data=0xFFFF8001, size=01, memory word=0xAAAABBBB -> write 0x8001BBBB.
- Misaligned half (addr=0x401) and illegal size 11 -> no mem_rd/mem_wr, done with err=1 at cycle 2.
- Wait states: ack delayed 3 cycles on both read and write -> strobes, address and wdata held stable throughout; req_ready_o=0 until done.
- Reset asserted during READ -> next cycle IDLE, all strobes 0, req_ready_o=1; a fresh word store then completes normally.
